console_rx: RTL and testbench
=============================

// Module: console_rx
// PURPOSE
//  Serial receive front end for the console. Oversamples the rx pin, deserialises
//  8N1 frames LSB-first and buffers received bytes in an internal FIFO.
//  The Wishbone console read path pops bytes through a rd/dout/empty interface.
//  It is the receive counterpart that consumes the line driven by a remote transmitter.
// PARAMETERS
//  FREQUENCY   25000000  system clock frequency in Hz
//  BAUD_RATE   115200    line baud rate
//  OVERSAMPLE  16        sample ticks per bit; even, >=4
//  DATA_BITS   8         data bits per frame
//  FIFO_DEPTH  16        receive FIFO entries; power of 2
//  TICK_DIV    derived   FREQUENCY/(BAUD_RATE*OVERSAMPLE), truncated, >=1 (elaboration error if 0)
// PORTS
//  clk        in   1                         system clock
//  rst        in   1                         synchronous reset, active-high
//  rx         in   1                         asynchronous serial input, idle high
//  rd         in   1                         pop head of FIFO this cycle
//  dout       out  DATA_BITS                 head of FIFO (first-word-fall-through)
//  empty      out  1                         FIFO holds no bytes
//  full       out  1                         FIFO holds FIFO_DEPTH bytes
//  count      out  $clog2(FIFO_DEPTH+1)      bytes in FIFO
//  frame_err  out  1                         one-cycle pulse: stop bit sampled low
//  overrun    out  1                         one-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset: dout=0, empty=1, full=0, count=0, frame_err=0, overrun=0.
//   Also: FSM=IDLE, armed=0, tick counter=0, both synchroniser flops=1.
//  rx passes through a 2-flop synchroniser to rx_s; all decisions use rx_s only.
//  Tick: free-running counter 0..TICK_DIV-1; tick=1 for one clk when the counter wraps.
//  FSM; counters advance only on tick; sample_cnt counts ticks within the current bit.
//   IDLE : on tick, rx_s=1 sets armed. If armed and rx_s=0 -> START, sample_cnt=0.
//   START: at sample_cnt=OVERSAMPLE/2-1 (mid start bit):
//          rx_s=0 -> DATA, sample_cnt=0, bit_cnt=0.
//          rx_s=1 -> glitch, IDLE; nothing reported.
//   DATA : at sample_cnt=OVERSAMPLE-1, shift rx_s into shreg MSB (shift right, LSB-first).
//          When bit_cnt=DATA_BITS-1 -> STOP; otherwise bit_cnt+1.
//   STOP : at sample_cnt=OVERSAMPLE-1 -> IDLE, armed=0.
//          rx_s=1: push shreg; if full, drop it and pulse overrun instead.
//          rx_s=0: discard byte, pulse frame_err; rx must return high to re-arm.
//  Push occurs in the clk after the stop-bit sample.
//  Frame-to-FIFO latency: mid-stop sample + 1 clk (+2 clk synchroniser on the rx edge).
//  FIFO: circular, wr/rd pointers wrap modulo FIFO_DEPTH.
//   dout = mem[rd_ptr] whenever !empty; dout is don't-care when empty.
//   rd while empty is ignored: no pointer or count change.
//   push and rd in the same cycle: both execute, count unchanged.
//   This includes the full case, so no overrun and order is preserved.
//   count, empty and full are registered and consistent with each other every cycle.
//  frame_err and overrun never assert in the same cycle; each is exactly 1 clk wide.
//  Reset mid-frame aborts the frame, clears the FIFO, requires re-arm (rx high one tick).
// TESTING (use FREQUENCY=1600, BAUD_RATE=100 -> TICK_DIV=1, 16 clk per bit)
//  1 Send frame 0x55 -> ~1 clk after mid-stop: empty=0, dout=8'h55, count=1.
//    Then rd=1 for 1 clk -> empty=1, count=0.
//  2 Drive rx low for 4 clk, then high -> no push, no frame_err, FSM back to IDLE.
//  3 Send 0xA3 with stop bit 0 -> frame_err single pulse, count unchanged.
//    Then rx high 16 clk, send 0x41 -> dout=8'h41.
//  4 Send 17 bytes 0x00..0x10 with no rd -> count=16, full=1.
//    overrun pulses once on the 17th byte; dout=8'h00.
//  5 At full, assert rd in the same clk as 18th byte's push -> count stays 16.
//    Draining yields 0x01..0x0F, then the 18th byte.
//  6 Assert rst during data bit 3 of a frame -> empty=1, count=0, no pulses.
//    Next complete frame 0x7E is received correctly.

Source files
------------

// File: rtl/console_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_rx                                                               |
// | Oversampling 8N1 serial receiver feeding a first-word-fall-through FIFO. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module console_rx #(
    parameter int FREQUENCY  = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    input  logic                              rd,
    output logic [DATA_BITS-1:0]              dout,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              frame_err,
    output logic                              overrun
);
    localparam int c_tick_div = FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int c_tw       = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;
    localparam int c_sw       = $clog2(OVERSAMPLE);
    localparam int c_bw       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int c_aw       = $clog2(FIFO_DEPTH);
    localparam int c_cw       = $clog2(FIFO_DEPTH + 1);

    generate
        if (c_tick_div < 1) begin : g_bad_tick_div
            $error("console_rx: FREQUENCY too low for BAUD_RATE*OVERSAMPLE");
        end
        if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
            $error("console_rx: OVERSAMPLE must be even and >= 4");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("console_rx: FIFO_DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state, w_state_n;
    logic                   r_rx_meta, r_rx_s;
    logic [c_tw-1:0]        r_tick_cnt;
    logic                   w_tick;
    logic [c_sw-1:0]        r_sample_cnt, w_sample_n;
    logic [c_bw-1:0]        r_bit_cnt, w_bit_n;
    logic [DATA_BITS-1:0]   r_shreg, w_shreg_n;
    logic                   r_armed, w_armed_n;
    logic                   r_push_req, w_push_n;
    logic                   r_frame_err, w_ferr_n;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]        r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0]        r_count, w_count_n;
    logic                   r_empty, r_full, r_overrun;
    logic                   w_wr, w_rd, w_ovr;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_tick_cnt == c_tw'(c_tick_div - 1));

    always_ff @(posedge clk) begin
        if (rst)         r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_armed      <= 1'b0;
            r_push_req   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_sample_cnt <= w_sample_n;
            r_bit_cnt    <= w_bit_n;
            r_shreg      <= w_shreg_n;
            r_armed      <= w_armed_n;
            r_push_req   <= w_push_n;
            r_frame_err  <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_sample_n = r_sample_cnt;
        w_bit_n    = r_bit_cnt;
        w_shreg_n  = r_shreg;
        w_armed_n  = r_armed;
        w_push_n   = 1'b0;
        w_ferr_n   = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_rx_s) begin
                        w_armed_n = 1'b1;
                    end else if (r_armed) begin
                        w_state_n  = S_START;
                        w_sample_n = '0;
                    end
                end
                S_START: begin
                    if (r_sample_cnt == c_sw'(OVERSAMPLE / 2 - 1)) begin
                        if (!r_rx_s) begin
                            w_state_n  = S_DATA;
                            w_sample_n = '0;
                            w_bit_n    = '0;
                        end else begin
                            w_state_n  = S_IDLE;
                        end
                    end else begin
                        w_sample_n = r_sample_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_sample_cnt == c_sw'(OVERSAMPLE - 1)) begin
                        w_sample_n = '0;
                        w_shreg_n  = {r_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bw'(DATA_BITS - 1)) w_state_n = S_STOP;
                        else                                   w_bit_n   = r_bit_cnt + 1'b1;
                    end else begin
                        w_sample_n = r_sample_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_sample_cnt == c_sw'(OVERSAMPLE - 1)) begin
                        w_state_n  = S_IDLE;
                        w_sample_n = '0;
                        w_armed_n  = 1'b0;
                        w_push_n   = r_rx_s;
                        w_ferr_n   = !r_rx_s;
                    end else begin
                        w_sample_n = r_sample_cnt + 1'b1;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // A pop at full frees the slot the pending push needs, so no overrun then.
    assign w_rd  = rd & !r_empty;
    assign w_wr  = r_push_req & (!r_full | w_rd);
    assign w_ovr = r_push_req & r_full & !w_rd;

    always_comb begin
        w_count_n = r_count;
        if (w_wr && !w_rd)      w_count_n = r_count + 1'b1;
        else if (!w_wr && w_rd) w_count_n = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= w_count_n;
            r_empty   <= (w_count_n == '0);
            r_full    <= (w_count_n == c_cw'(FIFO_DEPTH));
            r_overrun <= w_ovr;
        end
    end

    assign dout      = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty     = r_empty;
    assign full      = r_full;
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_console_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_console_rx                                                            |
// | Directed self-checking bench for console_rx (16 clk per bit).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_console_rx;
    logic       clk = 1'b0;
    logic       rst, rx, rd;
    logic [7:0] dout;
    logic       empty, full, frame_err, overrun;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    int ferr_pulses = 0;
    int ovr_pulses = 0;
    logic [4:0] cnt_before, cnt_after;

    console_rx #(
        .FREQUENCY (1600),
        .BAUD_RATE (100),
        .OVERSAMPLE(16),
        .DATA_BITS (8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rd       (rd),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_pulses++;
        if (overrun)   ovr_pulses++;
    end

    // One 160-clk frame; mid-stop sample lands at c=155, push completes at c=156.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic rd_at_push, input int rst_at);
        for (int c = 0; c < 160; c++) begin
            int b;
            @(posedge clk); #1;
            b = c / 16;
            if (b == 0)      rx = 1'b0;
            else if (b <= 8) rx = data[b-1];
            else             rx = stop;
            rd  = rd_at_push && (c == 155);
            rst = (c == rst_at);
            if (c == 155) cnt_before = count;
            if (c == 156) cnt_after  = count;
        end
        @(posedge clk); #1;
        rx = 1'b1; rd = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop();
        @(posedge clk); #1; rd = 1'b1;
        @(posedge clk); #1; rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rd = 1'b0;
        idle(3);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_single();
        send_frame(8'h55, 1'b1, 1'b0, -1);
        checks++; if (cnt_before !== 5'd0) begin errors++; $display("FAIL single_pre_count got %0d exp 0", cnt_before); end
        checks++; if (cnt_after !== 5'd1) begin errors++; $display("FAIL single_latency_count got %0d exp 1", cnt_after); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
        checks++; if (dout !== 8'h55) begin errors++; $display("FAIL single_dout got %h exp 55", dout); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        pop();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b exp 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_pulses;
        @(posedge clk); #1; rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL glitch_count got %0d exp 0", count); end
        checks++; if (ferr_pulses !== f0) begin errors++; $display("FAIL glitch_ferr got %0d exp %0d", ferr_pulses, f0); end
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        checks++; if (dout !== 8'hC3) begin errors++; $display("FAIL glitch_next_dout got %h exp c3", dout); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL glitch_next_count got %0d exp 1", count); end
        pop();
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_pulses;
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        checks++; if (ferr_pulses !== f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", ferr_pulses, f0 + 1); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL ferr_count got %0d exp 0", count); end
        idle(16);
        send_frame(8'h41, 1'b1, 1'b0, -1);
        checks++; if (dout !== 8'h41) begin errors++; $display("FAIL ferr_next_dout got %h exp 41", dout); end
        checks++; if (ferr_pulses !== f0 + 1) begin errors++; $display("FAIL ferr_next_pulse got %0d exp %0d", ferr_pulses, f0 + 1); end
        pop();
    endtask

    task automatic test_overrun();
        int o0;
        logic [7:0] d;
        o0 = ovr_pulses;
        for (int i = 0; i < 17; i++) begin
            d = 8'(i);
            send_frame(d, 1'b1, 1'b0, -1);
        end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovr_count got %0d exp 16", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovr_full got %b exp 1", full); end
        checks++; if (ovr_pulses !== o0 + 1) begin errors++; $display("FAIL ovr_pulse got %0d exp %0d", ovr_pulses, o0 + 1); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ovr_dout got %h exp 00", dout); end
    endtask

    task automatic test_back_to_back();
        int o0;
        logic [7:0] exp_d;
        o0 = ovr_pulses;
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        checks++; if (cnt_after !== 5'd16) begin errors++; $display("FAIL b2b_push_count got %0d exp 16", cnt_after); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL b2b_count got %0d exp 16", count); end
        checks++; if (ovr_pulses !== o0) begin errors++; $display("FAIL b2b_ovr got %0d exp %0d", ovr_pulses, o0); end
        for (int i = 1; i <= 16; i++) begin
            exp_d = (i == 16) ? 8'h5A : 8'(i);
            checks++; if (dout !== exp_d) begin errors++; $display("FAIL b2b_drain_%0d got %h exp %h", i, dout, exp_d); end
            pop();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        int f0, o0;
        send_frame(8'h99, 1'b1, 1'b0, -1);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 1", count); end
        f0 = ferr_pulses; o0 = ovr_pulses;
        // Bits 3..7 of 0xF8 are high, so the line stays idle after the reset.
        send_frame(8'hF8, 1'b1, 1'b0, 72);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
        checks++; if ((ferr_pulses !== f0) || (ovr_pulses !== o0)) begin
            errors++; $display("FAIL rstmid_pulses got ferr=%0d ovr=%0d exp ferr=%0d ovr=%0d", ferr_pulses, ovr_pulses, f0, o0);
        end
        idle(20);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        checks++; if (dout !== 8'h7E) begin errors++; $display("FAIL rstmid_next_dout got %h exp 7e", dout); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL rstmid_next_count got %0d exp 1", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
